// File: rtl/board_pkg.sv
// ----------------------------------------------------------------------------
// board_pkg
// Board-wide constants for the Genesys 2 design running from the 200 MHz
// system clock. Timing parameters of board peripherals derive their default
// values from these so that every block agrees on cycles per millisecond.
// ----------------------------------------------------------------------------
package board_pkg;

    localparam int unsigned CLK_FREQ_HZ   = 200_000_000;
    localparam int unsigned CYCLES_PER_MS = CLK_FREQ_HZ / 1000;

endpackage

// File: rtl/button_debouncer_if.sv
// ----------------------------------------------------------------------------
// button_debouncer_if
// Bundles the raw button pin and the conditioned button signals.
//   btn_in      : raw, bouncy, asynchronous button pin (active-high)
//   btn_level   : debounced level, 1 = pressed
//   btn_press   : one-cycle strobe on an accepted 0->1 transition
//   btn_release : one-cycle strobe on an accepted 1->0 transition
//   long_press  : one-cycle strobe once the press has been held long enough
// master : the debouncer (consumes btn_in, produces the conditioned signals)
// slave  : the pin/user side (drives btn_in, consumes the conditioned signals)
// ----------------------------------------------------------------------------
interface button_debouncer_if;

    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic long_press;

    modport master (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output long_press
    );

    modport slave (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  long_press
    );

endinterface

// File: rtl/button_debouncer_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for asynchronous board inputs: d -> s0 -> q.
//   clk_200mhz : destination clock
//   reset_n    : asynchronous active-low reset, clears both stages
//   d          : asynchronous input(s)
//   q          : synchronized output(s), two edges behind d
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_200mhz,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s0;

    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            s0 <= '0;
            q  <= '0;
        end else begin
            s0 <= d;
            q  <= s0;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
// Conditions a raw push-button into a debounced level plus one-cycle press,
// release and long-press strobes in the 200 MHz domain. All outputs are
// registered; btn_level changes on the same edge as the matching strobe.
//   clk_200mhz : system clock
//   reset_n    : asynchronous active-low reset
//   bus        : button_debouncer_if.master (btn_in in, conditioned outputs)
// ----------------------------------------------------------------------------
module button_debouncer
    import board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 10 * CYCLES_PER_MS,
    parameter int unsigned LONG_PRESS_CYCLES = CLK_FREQ_HZ,
    parameter int unsigned DB_W              = $clog2(DEBOUNCE_CYCLES),
    parameter int unsigned LP_W              = $clog2(LONG_PRESS_CYCLES)
) (
    input  logic                clk_200mhz,
    input  logic                reset_n,
    button_debouncer_if.master  bus
);

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_PRE  = LP_W'(LONG_PRESS_CYCLES - 2);

    logic            s1;
    state_t          state_q, state_d;
    logic [DB_W-1:0] db_q, db_d;
    logic [LP_W-1:0] lp_q, lp_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            long_q, long_d;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk_200mhz (clk_200mhz),
        .reset_n    (reset_n),
        .d          (bus.btn_in),
        .q          (s1)
    );

    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RELEASED;
            db_q      <= '0;
            lp_q      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_q      <= db_d;
            lp_q      <= lp_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        db_d      = db_q;
        lp_d      = lp_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        unique case (state_q)
            RELEASED: begin
                if (s1) begin
                    state_d = DB_PRESS;
                    db_d    = DB_W'(1);
                end
            end
            DB_PRESS: begin
                if (!s1) begin
                    state_d = RELEASED;
                    db_d    = '0;
                end else if (db_q == DB_LAST) begin
                    state_d = PRESSED;
                    db_d    = '0;
                    press_d = 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s1) begin
                    state_d = DB_RELEASE;
                    db_d    = DB_W'(1);
                end
            end
            DB_RELEASE: begin
                if (s1) begin
                    state_d = PRESSED;
                    db_d    = '0;
                end else if (db_q == DB_LAST) begin
                    state_d   = RELEASED;
                    db_d      = '0;
                    release_d = 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase

        // Hold time keeps counting through a release bounce; the accepted
        // release edge clears it and suppresses a coincident long_press.
        if (release_d) begin
            lp_d = '0;
        end else if ((state_q == PRESSED || state_q == DB_RELEASE) &&
                     (lp_q != LP_LAST)) begin
            lp_d   = lp_q + 1'b1;
            long_d = (lp_q == LP_PRE);
        end

        level_d = (state_d == PRESSED) || (state_d == DB_RELEASE);
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.long_press  = long_q;

endmodule
